// File: rtl/fpu_exception_simd.sv
// Multi-lane IEEE-754 exception and result-override stage.
// Classifies operands, raises OF/UF/DZ/NV/NX per lane, substitutes qNaN/Inf/zero,
// and registers the beat behind a two-entry valid/ready skid buffer with sticky flags and trap.
module fpu_exception_simd #(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned LANES     = 4,
  parameter int unsigned EXP_WIDTH = (BIT_WIDTH == 64) ? 11 : 8,
  parameter int unsigned MAN_WIDTH = (BIT_WIDTH == 64) ? 52 : 23
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [1:0]                 i_operation,
  input  logic [LANES-1:0]           i_lane_en,
  input  logic [LANES*BIT_WIDTH-1:0] i_inputA,
  input  logic [LANES*BIT_WIDTH-1:0] i_inputB,
  input  logic [LANES*BIT_WIDTH-1:0] i_add_out,
  input  logic [LANES*BIT_WIDTH-1:0] i_sub_out,
  input  logic [LANES*BIT_WIDTH-1:0] i_mul_out,
  input  logic [LANES*BIT_WIDTH-1:0] i_div_out,
  input  logic [LANES-1:0]           i_add_inexact,
  input  logic [LANES-1:0]           i_sub_inexact,
  input  logic [LANES-1:0]           i_mul_inexact,
  input  logic [LANES-1:0]           i_div_inexact,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [LANES*BIT_WIDTH-1:0] o_result,
  output logic [LANES*5-1:0]         o_exception,
  input  logic                       i_sticky_clr,
  input  logic [4:0]                 i_trap_en,
  output logic [4:0]                 o_sticky,
  output logic                       o_trap
);

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpDiv = 2'b11;

  // Canonical quiet NaN, sign 0, top mantissa bit set.
  localparam logic [BIT_WIDTH-1:0] QNan =
      {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

  logic [LANES*BIT_WIDTH-1:0] beat_res;
  logic [LANES*5-1:0]         beat_exc;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [BIT_WIDTH-1:0] a, b, raw, res;
    logic                 raw_nx;
    logic [EXP_WIDTH-1:0] a_exp, b_exp, r_exp;
    logic [MAN_WIDTH-1:0] a_man, b_man;
    logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic                 sa, sb;
    logic                 nv, dz, of, uf, nx;

    assign a      = i_inputA[k*BIT_WIDTH +: BIT_WIDTH];
    assign b      = i_inputB[k*BIT_WIDTH +: BIT_WIDTH];
    assign sa     = a[BIT_WIDTH-1];
    assign sb     = b[BIT_WIDTH-1];
    assign a_exp  = a[BIT_WIDTH-2 -: EXP_WIDTH];
    assign b_exp  = b[BIT_WIDTH-2 -: EXP_WIDTH];
    assign a_man  = a[MAN_WIDTH-1:0];
    assign b_man  = b[MAN_WIDTH-1:0];
    assign a_nan  = (&a_exp) & (|a_man);
    assign b_nan  = (&b_exp) & (|b_man);
    assign a_inf  = (&a_exp) & ~(|a_man);
    assign b_inf  = (&b_exp) & ~(|b_man);
    assign a_zero = ~(|a_exp) & ~(|a_man);
    assign b_zero = ~(|b_exp) & ~(|b_man);
    assign r_exp  = raw[BIT_WIDTH-2 -: EXP_WIDTH];

    // Select the raw core result and its inexact bit for the current operation.
    always_comb begin
      raw    = '0;
      raw_nx = 1'b0;
      unique case (i_operation)
        OpAdd: begin raw = i_add_out[k*BIT_WIDTH +: BIT_WIDTH]; raw_nx = i_add_inexact[k]; end
        OpSub: begin raw = i_sub_out[k*BIT_WIDTH +: BIT_WIDTH]; raw_nx = i_sub_inexact[k]; end
        OpMul: begin raw = i_mul_out[k*BIT_WIDTH +: BIT_WIDTH]; raw_nx = i_mul_inexact[k]; end
        OpDiv: begin raw = i_div_out[k*BIT_WIDTH +: BIT_WIDTH]; raw_nx = i_div_inexact[k]; end
      endcase
    end

    // Raise flags; an invalid operation masks every other flag.
    always_comb begin
      nv = a_nan | b_nan;
      unique case (i_operation)
        OpAdd: nv = nv | (a_inf & b_inf & (sa != sb));
        OpSub: nv = nv | (a_inf & b_inf & (sa == sb));
        OpMul: nv = nv | (a_zero & b_inf) | (a_inf & b_zero);
        OpDiv: nv = nv | (a_zero & b_zero) | (a_inf & b_inf);
      endcase
      dz = ~nv & (i_operation == OpDiv) & b_zero & ~a_zero & ~a_inf & ~a_nan;
      of = ~nv & (&r_exp) & raw_nx & ~a_inf & ~b_inf;
      uf = ~nv & ~(|r_exp) & raw_nx;
      nx = ~nv & (raw_nx | of);
    end

    // Override the result by flag priority NV > DZ > OF > UF.
    always_comb begin
      res = raw;
      if (nv) begin
        res = QNan;
      end else if (dz) begin
        res = {sa ^ sb, {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
      end else if (of) begin
        res = {raw[BIT_WIDTH-1], {EXP_WIDTH{1'b1}}, {MAN_WIDTH{1'b0}}};
      end else if (uf) begin
        res = {raw[BIT_WIDTH-1], {(BIT_WIDTH-1){1'b0}}};
      end
    end

    assign beat_res[k*BIT_WIDTH +: BIT_WIDTH] = i_lane_en[k] ? res : '0;
    assign beat_exc[k*5 +: 5] = i_lane_en[k] ? {of, uf, dz, nv, nx} : 5'b0;
  end

  state_e                     state_q, state_d;
  logic [LANES*BIT_WIDTH-1:0] out_res_q, out_res_d, skid_res_q, skid_res_d;
  logic [LANES*5-1:0]         out_exc_q, out_exc_d, skid_exc_q, skid_exc_d;
  logic [4:0]                 sticky_q, sticky_d;
  logic                       trap_q, trap_d;
  logic [4:0]                 beat_flags;
  logic                       accept, transfer;

  assign o_ready     = (state_q != StFull);
  assign o_valid     = (state_q != StEmpty);
  assign accept      = i_valid & o_ready;
  assign transfer    = o_valid & i_ready;
  assign o_result    = out_res_q;
  assign o_exception = out_exc_q;
  assign o_sticky    = sticky_q;
  assign o_trap      = trap_q;

  // OR the flags of all lanes in the beat currently presented downstream.
  always_comb begin
    beat_flags = '0;
    for (int k = 0; k < LANES; k++) begin
      beat_flags = beat_flags | out_exc_q[k*5 +: 5];
    end
  end

  // Skid-buffer control: output register first, skid entry only when stalled.
  always_comb begin
    state_d    = state_q;
    out_res_d  = out_res_q;
    out_exc_d  = out_exc_q;
    skid_res_d = skid_res_q;
    skid_exc_d = skid_exc_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          out_res_d = beat_res;
          out_exc_d = beat_exc;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        if (accept && transfer) begin
          out_res_d = beat_res;
          out_exc_d = beat_exc;
        end else if (accept) begin
          skid_res_d = beat_res;
          skid_exc_d = beat_exc;
          state_d    = StFull;
        end else if (transfer) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (transfer) begin
          out_res_d = skid_res_q;
          out_exc_d = skid_exc_q;
          state_d   = StBusy;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Sticky flags and trap; a trapping transfer wins over a simultaneous clear.
  always_comb begin
    sticky_d = sticky_q;
    if (i_sticky_clr && transfer) begin
      sticky_d = beat_flags;
    end else if (i_sticky_clr) begin
      sticky_d = '0;
    end else if (transfer) begin
      sticky_d = sticky_q | beat_flags;
    end
    trap_d = trap_q;
    if (transfer && |(beat_flags & i_trap_en)) begin
      trap_d = 1'b1;
    end else if (i_sticky_clr) begin
      trap_d = 1'b0;
    end
  end

  // State and data registers, all cleared by asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      out_res_q  <= '0;
      out_exc_q  <= '0;
      skid_res_q <= '0;
      skid_exc_q <= '0;
      sticky_q   <= '0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_res_q  <= out_res_d;
      out_exc_q  <= out_exc_d;
      skid_res_q <= skid_res_d;
      skid_exc_q <= skid_exc_d;
      sticky_q   <= sticky_d;
      trap_q     <= trap_d;
    end
  end

endmodule
